// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared encodings for the ARM-subset decode stage:
//   - instruction mode field values
//   - data-processing opcodes and the EX-stage command codes they map to
//   - condition codes (EQ..AL, plus NV which always fails)
//   - ctrl_t: control bundle carried from ID into EX
// -----------------------------------------------------------------------------
package id_pkg;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  // Data-processing opcodes (instr[24:21])
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // EX-stage ALU commands
  localparam logic [3:0] EXC_NOP = 4'b0000;
  localparam logic [3:0] EXC_MOV = 4'b0001;
  localparam logic [3:0] EXC_ADD = 4'b0010;
  localparam logic [3:0] EXC_ADC = 4'b0011;
  localparam logic [3:0] EXC_SUB = 4'b0100;
  localparam logic [3:0] EXC_SBC = 4'b0101;
  localparam logic [3:0] EXC_AND = 4'b0110;
  localparam logic [3:0] EXC_ORR = 4'b0111;
  localparam logic [3:0] EXC_EOR = 4'b1000;
  localparam logic [3:0] EXC_MVN = 4'b1001;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'ha,
    COND_LT = 4'hb,
    COND_GT = 4'hc,
    COND_LE = 4'hd,
    COND_AL = 4'he,
    COND_NV = 4'hf
  } cond_e;

  typedef struct packed {
    logic       update;
    logic       b;
    logic [3:0] ex_cmd;
    logic       mem_w;
    logic       mem_r;
    logic       wb;
    logic       imm;
  } ctrl_t;

endpackage

// File: rtl/id_stage_pipelined_if.sv
// -----------------------------------------------------------------------------
// id_stage_pipelined_if
// ID/EX bus: the registered decode results flowing to EX plus the two
// back-pressure/kill signals EX returns to ID.
//   master (ID side): drives the ID/EX fields, receives ex_stall and flush
//   slave  (EX side): receives the ID/EX fields, drives ex_stall and flush
// -----------------------------------------------------------------------------
interface id_stage_pipelined_if #(
  parameter int WORD_WIDTH = 32
) ();

  logic                  ex_stall;
  logic                  flush;

  logic                  out_valid;
  logic [WORD_WIDTH-1:0] pc_out;
  logic [WORD_WIDTH-1:0] reg_val1;
  logic [WORD_WIDTH-1:0] reg_val2;
  logic [3:0]            dst;
  logic [3:0]            src1_out;
  logic [3:0]            src2_out;
  logic [11:0]           shifter_operand;
  logic [23:0]           signed_immediate;
  logic [3:0]            ex_command;
  logic                  mem_read;
  logic                  mem_write;
  logic                  wb_en_out;
  logic                  imm;
  logic                  b;
  logic                  s_update;

  modport master (
    input  ex_stall, flush,
    output out_valid, pc_out, reg_val1, reg_val2, dst, src1_out, src2_out,
           shifter_operand, signed_immediate, ex_command,
           mem_read, mem_write, wb_en_out, imm, b, s_update
  );

  modport slave (
    output ex_stall, flush,
    input  out_valid, pc_out, reg_val1, reg_val2, dst, src1_out, src2_out,
           shifter_operand, signed_immediate, ex_command,
           mem_read, mem_write, wb_en_out, imm, b, s_update
  );

endinterface

// File: rtl/id_regfile.sv
// -----------------------------------------------------------------------------
// id_regfile
// NUM_REGS-entry register file, two combinational read ports, one write port.
// A write in the same cycle as a read of the same register is bypassed to the
// read port (write-through); the array itself updates at posedge.
// Indices >= NUM_REGS are unimplemented: they read 0 and writes are dropped.
// Ports:
//   clk, rst            clock, synchronous active-low clear of all entries
//   wr_en/addr/data     write port
//   rd_addr1/rd_data1   read port 1
//   rd_addr2/rd_data2   read port 2
// -----------------------------------------------------------------------------
module id_regfile #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_REGS   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [3:0]            rd_addr1,
  output logic [WORD_WIDTH-1:0] rd_data1,
  input  logic [3:0]            rd_addr2,
  output logic [WORD_WIDTH-1:0] rd_data2
);

  logic [WORD_WIDTH-1:0] regs [NUM_REGS];

  function automatic logic implemented(input logic [3:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == 4'(i)) regs[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data1 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr1 == 4'(i)) rd_data1 = regs[i];
    end
    if (wr_en && wr_addr == rd_addr1 && implemented(rd_addr1)) rd_data1 = wr_data;
  end

  always_comb begin
    rd_data2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr2 == 4'(i)) rd_data2 = regs[i];
    end
    if (wr_en && wr_addr == rd_addr2 && implemented(rd_addr2)) rd_data2 = wr_data;
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// id_stage_pipelined
// Decode stage of the ARM-subset pipeline: decodes the instruction, evaluates
// its condition against {N,Z,C,V}, reads the register file, detects RAW hazards
// and owns the ID/EX pipeline register.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   in_valid, pc_in,      IF/ID contents (pc_in is PC+4)
//   instruction_in
//   status_register       {N,Z,C,V}
//   wb_en/addr/data       register-file write-back port
//   ex_wb_en, ex_mem_read, ex_dst   destination of the instruction in EX
//   mem_wb_en, mem_dst              destination of the instruction in MEM
//   id_ready              instruction consumed this cycle
//   hazard                RAW stall request to IF
//   idex (master)         registered ID/EX fields out; ex_stall, flush in
//
// Build option ID_FORWARDING_EN: when defined, only load-use against EX
// stalls; otherwise every pending EX/MEM write to a used source stalls.
// -----------------------------------------------------------------------------
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_REGS   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] pc_in,
  input  logic [31:0]           instruction_in,
  input  logic [3:0]            status_register,
  input  logic                  wb_en,
  input  logic [3:0]            wb_addr,
  input  logic [WORD_WIDTH-1:0] wb_data,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_read,
  input  logic [3:0]            ex_dst,
  input  logic                  mem_wb_en,
  input  logic [3:0]            mem_dst,
  output logic                  id_ready,
  output logic                  hazard,
  id_stage_pipelined_if.master  idex
);

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond_e'(cond))
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_CS: r = c;
      COND_CC: r = !c;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = c && !z;
      COND_LS: r = !c || z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = !z && (n == v);
      COND_LE: r = z || (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // ---- Stage p0: decode, condition check, register read, hazard ----
  logic [3:0]            cond_p0, op_p0, rn_p0, rd_p0, src2_p0;
  mode_e                 mode_p0;
  logic                  i_p0, s_p0, is_str_p0;
  logic                  uses_src1_p0, uses_src2_p0;
  logic                  match1_p0, match2_p0;
  ctrl_t                 ctrl_dec_p0, ctrl_p0;
  logic [WORD_WIDTH-1:0] val1_p0, val2_p0;

  assign cond_p0   = instruction_in[31:28];
  assign mode_p0   = mode_e'(instruction_in[27:26]);
  assign i_p0      = instruction_in[25];
  assign op_p0     = instruction_in[24:21];
  assign s_p0      = instruction_in[20];
  assign rn_p0     = instruction_in[19:16];
  assign rd_p0     = instruction_in[15:12];
  assign is_str_p0 = (mode_p0 == MODE_MEM) && !s_p0;
  assign src2_p0   = is_str_p0 ? rd_p0 : instruction_in[3:0];

  always_comb begin
    ctrl_dec_p0 = '0;
    case (mode_p0)
      MODE_DP: begin
        ctrl_dec_p0.imm    = i_p0;
        ctrl_dec_p0.update = s_p0;
        ctrl_dec_p0.wb     = 1'b1;
        case (op_p0)
          OP_MOV:  ctrl_dec_p0.ex_cmd = EXC_MOV;
          OP_MVN:  ctrl_dec_p0.ex_cmd = EXC_MVN;
          OP_ADD:  ctrl_dec_p0.ex_cmd = EXC_ADD;
          OP_ADC:  ctrl_dec_p0.ex_cmd = EXC_ADC;
          OP_SUB:  ctrl_dec_p0.ex_cmd = EXC_SUB;
          OP_SBC:  ctrl_dec_p0.ex_cmd = EXC_SBC;
          OP_AND:  ctrl_dec_p0.ex_cmd = EXC_AND;
          OP_ORR:  ctrl_dec_p0.ex_cmd = EXC_ORR;
          OP_EOR:  ctrl_dec_p0.ex_cmd = EXC_EOR;
          OP_CMP: begin
            ctrl_dec_p0.ex_cmd = EXC_SUB;
            ctrl_dec_p0.wb     = 1'b0;
          end
          OP_TST: begin
            ctrl_dec_p0.ex_cmd = EXC_AND;
            ctrl_dec_p0.wb     = 1'b0;
          end
          default: begin
            // Opcodes outside the subset execute as a no-op.
            ctrl_dec_p0.ex_cmd = EXC_NOP;
            ctrl_dec_p0.wb     = 1'b0;
          end
        endcase
      end
      MODE_MEM: begin
        ctrl_dec_p0.ex_cmd = EXC_ADD;
        ctrl_dec_p0.imm    = 1'b1;
        ctrl_dec_p0.mem_r  = s_p0;
        ctrl_dec_p0.wb     = s_p0;
        ctrl_dec_p0.mem_w  = !s_p0;
      end
      MODE_BR:  ctrl_dec_p0.b = 1'b1;
      default:  ctrl_dec_p0 = '0;
    endcase
  end

  // A failed condition kills every side effect; imm only selects an operand.
  always_comb begin
    ctrl_p0 = ctrl_dec_p0;
    if (!cond_pass(cond_p0, status_register)) begin
      ctrl_p0     = '0;
      ctrl_p0.imm = ctrl_dec_p0.imm;
    end
  end

  id_regfile #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data),
    .rd_addr1 (rn_p0),
    .rd_data1 (val1_p0),
    .rd_addr2 (src2_p0),
    .rd_data2 (val2_p0)
  );

  assign uses_src1_p0 = (mode_p0 != MODE_BR) &&
                        !((mode_p0 == MODE_DP) && (op_p0 == OP_MOV || op_p0 == OP_MVN));
  assign uses_src2_p0 = ((mode_p0 == MODE_DP) && !i_p0) || is_str_p0;

`ifdef ID_FORWARDING_EN
  // Forwarding covers everything except a load still in EX.
  logic unused_mem_ports;
  assign unused_mem_ports = ^{mem_wb_en, mem_dst};
  assign match1_p0 = ex_wb_en && ex_mem_read && (ex_dst == rn_p0);
  assign match2_p0 = ex_wb_en && ex_mem_read && (ex_dst == src2_p0);
`else
  logic unused_ex_mem_read;
  assign unused_ex_mem_read = ex_mem_read;
  assign match1_p0 = (ex_wb_en && (ex_dst == rn_p0)) || (mem_wb_en && (mem_dst == rn_p0));
  assign match2_p0 = (ex_wb_en && (ex_dst == src2_p0)) || (mem_wb_en && (mem_dst == src2_p0));
`endif

  assign hazard   = in_valid && ((uses_src1_p0 && match1_p0) || (uses_src2_p0 && match2_p0));
  assign id_ready = in_valid && !hazard && !idex.ex_stall && !idex.flush;

  // ---- Stage p1: ID/EX register ----
  logic                  vld_p1;
  ctrl_t                 ctrl_p1;
  logic [WORD_WIDTH-1:0] pc_p1, val1_p1, val2_p1;
  logic [3:0]            dst_p1, src1_p1, src2_p1;
  logic [11:0]           shop_p1;
  logic [23:0]           simm_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      pc_p1   <= '0;
      val1_p1 <= '0;
      val2_p1 <= '0;
      dst_p1  <= '0;
      src1_p1 <= '0;
      src2_p1 <= '0;
      shop_p1 <= '0;
      simm_p1 <= '0;
    end else if (idex.flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (idex.ex_stall) begin
      vld_p1  <= vld_p1;
      ctrl_p1 <= ctrl_p1;
    end else if (hazard || !in_valid) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else begin
      vld_p1  <= 1'b1;
      ctrl_p1 <= ctrl_p0;
      pc_p1   <= pc_in;
      val1_p1 <= val1_p0;
      val2_p1 <= val2_p0;
      dst_p1  <= rd_p0;
      src1_p1 <= rn_p0;
      src2_p1 <= src2_p0;
      shop_p1 <= instruction_in[11:0];
      simm_p1 <= instruction_in[23:0];
    end
  end

  assign idex.out_valid        = vld_p1;
  assign idex.pc_out           = pc_p1;
  assign idex.reg_val1         = val1_p1;
  assign idex.reg_val2         = val2_p1;
  assign idex.dst              = dst_p1;
  assign idex.src1_out         = src1_p1;
  assign idex.src2_out         = src2_p1;
  assign idex.shifter_operand  = shop_p1;
  assign idex.signed_immediate = simm_p1;
  assign idex.ex_command       = ctrl_p1.ex_cmd;
  assign idex.mem_read         = ctrl_p1.mem_r;
  assign idex.mem_write        = ctrl_p1.mem_w;
  assign idex.wb_en_out        = ctrl_p1.wb;
  assign idex.imm              = ctrl_p1.imm;
  assign idex.b                = ctrl_p1.b;
  assign idex.s_update         = ctrl_p1.update;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipelined
// Directed bench for id_stage_pipelined. Each clock cycle pushes the ID/EX
// contents it expects after the coming edge; the entry is popped and compared
// one time unit after that edge. Combinational hazard/id_ready are checked
// before the edge.
// -----------------------------------------------------------------------------
module tb_id_stage_pipelined;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic [3:0]  status_register;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_wb_en;
  logic        ex_mem_read;
  logic [3:0]  ex_dst;
  logic        mem_wb_en;
  logic [3:0]  mem_dst;
  logic        id_ready;
  logic        hazard;

  id_stage_pipelined_if #(.WORD_WIDTH(32)) idex ();

  id_stage_pipelined #(
    .WORD_WIDTH (32),
    .NUM_REGS   (15)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .pc_in           (pc_in),
    .instruction_in  (instruction_in),
    .status_register (status_register),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .ex_wb_en        (ex_wb_en),
    .ex_mem_read     (ex_mem_read),
    .ex_dst          (ex_dst),
    .mem_wb_en       (mem_wb_en),
    .mem_dst         (mem_dst),
    .id_ready        (id_ready),
    .hazard          (hazard),
    .idex            (idex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          full;
    logic        vld;
    logic [31:0] pc, v1, v2;
    logic [3:0]  dst, s1, s2, exc;
    logic [11:0] shop;
    logic [23:0] simm;
    logic        wb, mr, mw, b, s, imm;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dp(input logic [3:0] cond, input logic i, input logic [3:0] op,
                                     input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] op2);
    return {cond, 2'b00, i, op, s, rn, rd, op2};
  endfunction

  function automatic logic [31:0] mem(input logic ld, input logic [3:0] rn, input logic [3:0] rd,
                                      input logic [11:0] off);
    return {4'hE, 2'b01, 1'b0, 4'b0000, ld, rn, rd, off};
  endfunction

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] v1, input logic [31:0] v2,
                              input logic [3:0] dst, input logic [3:0] s1, input logic [3:0] s2,
                              input logic [3:0] exc, input logic wb, input logic mr,
                              input logic mw, input logic b, input logic s, input logic imm);
    exp_t e;
    e.full = 1'b1; e.vld = 1'b1;
    e.pc = pc; e.v1 = v1; e.v2 = v2;
    e.dst = dst; e.s1 = s1; e.s2 = s2; e.exc = exc;
    e.shop = instr[11:0]; e.simm = instr[23:0];
    e.wb = wb; e.mr = mr; e.mw = mw; e.b = b; e.s = s; e.imm = imm;
    return e;
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e = mk(32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    e.full = 1'b0; e.vld = 1'b0;
    return e;
  endfunction

  function automatic exp_t zero();
    exp_t e;
    e = bub();
    e.full = 1'b1;
    return e;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = iv; instruction_in = instr; pc_in = pc;
  endtask

  task automatic chk_comb(input string tag, input logic exp_hz, input logic exp_rdy);
    #1;
    chk({tag, ".hazard"}, hazard, exp_hz);
    chk({tag, ".id_ready"}, id_ready, exp_rdy);
  endtask

  task automatic cycle(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard_entry"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".out_valid"},  idex.out_valid,  e.vld);
      chk({tag, ".ex_command"}, idex.ex_command, e.exc);
      chk({tag, ".wb_en_out"},  idex.wb_en_out,  e.wb);
      chk({tag, ".mem_read"},   idex.mem_read,   e.mr);
      chk({tag, ".mem_write"},  idex.mem_write,  e.mw);
      chk({tag, ".b"},          idex.b,          e.b);
      chk({tag, ".s_update"},   idex.s_update,   e.s);
      chk({tag, ".imm"},        idex.imm,        e.imm);
      if (e.full) begin
        chk({tag, ".pc_out"},   idex.pc_out,   e.pc);
        chk({tag, ".reg_val1"}, idex.reg_val1, e.v1);
        chk({tag, ".reg_val2"}, idex.reg_val2, e.v2);
        chk({tag, ".dst"},      idex.dst,      e.dst);
        chk({tag, ".src1_out"}, idex.src1_out, e.s1);
        chk({tag, ".src2_out"}, idex.src2_out, e.s2);
        chk({tag, ".shifter_operand"},  idex.shifter_operand,  e.shop);
        chk({tag, ".signed_immediate"}, idex.signed_immediate, e.simm);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    exp_t        held;

    rst = 1'b0; status_register = 4'h0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    ex_wb_en = 0; ex_mem_read = 0; ex_dst = 0; mem_wb_en = 0; mem_dst = 0;
    idex.ex_stall = 0; idex.flush = 0;
    drive(0, 32'h0, 32'h0);

    // Reset state
    chk_comb("reset", 0, 0);
    sb.push_back(zero()); cycle("reset0");
    sb.push_back(zero()); cycle("reset1");

    // Load r2=5, r3=7
    rst = 1'b1;
    wb_en = 1; wb_addr = 4'd2; wb_data = 32'd5;
    sb.push_back(bub()); cycle("wr_r2");
    wb_addr = 4'd3; wb_data = 32'd7;
    sb.push_back(bub()); cycle("wr_r3");
    wb_en = 0;

    // ADD r1, r2, r3
    ins = dp(4'hE, 0, 4'b0100, 0, 4'd2, 4'd1, 12'h003);
    drive(1, ins, 32'h104);
    chk_comb("add", 0, 1);
    sb.push_back(mk(ins, 32'h104, 5, 7, 4'd1, 4'd2, 4'd3, 4'b0010, 1, 0, 0, 0, 0, 0));
    cycle("add");

    // SUB r4, r1, r2 with r1 pending in EX; r1 written back meanwhile
    ex_wb_en = 1; ex_dst = 4'd1;
    wb_en = 1; wb_addr = 4'd1; wb_data = 32'h11;
    ins = dp(4'hE, 0, 4'b0010, 0, 4'd1, 4'd4, 12'h002);
    drive(1, ins, 32'h108);
`ifdef ID_FORWARDING_EN
    chk_comb("sub_ex_hz", 0, 1);
    sb.push_back(mk(ins, 32'h108, 32'h11, 5, 4'd4, 4'd1, 4'd2, 4'b0100, 1, 0, 0, 0, 0, 0));
    cycle("sub_fwd");
    ex_wb_en = 0; wb_en = 0;
`else
    chk_comb("sub_ex_hz", 1, 0);
    sb.push_back(bub()); cycle("sub_bubble");
    ex_wb_en = 0; wb_en = 0;
    chk_comb("sub_retry", 0, 1);
    sb.push_back(mk(ins, 32'h108, 32'h11, 5, 4'd4, 4'd1, 4'd2, 4'b0100, 1, 0, 0, 0, 0, 0));
    cycle("sub_retry");
`endif

    // ADD r5, r2, r3 with r3 pending in MEM (src2 path)
    mem_wb_en = 1; mem_dst = 4'd3;
    ins = dp(4'hE, 0, 4'b0100, 0, 4'd2, 4'd5, 12'h003);
    drive(1, ins, 32'h10C);
`ifdef ID_FORWARDING_EN
    chk_comb("add_mem_hz", 0, 1);
    sb.push_back(mk(ins, 32'h10C, 5, 7, 4'd5, 4'd2, 4'd3, 4'b0010, 1, 0, 0, 0, 0, 0));
`else
    chk_comb("add_mem_hz", 1, 0);
    sb.push_back(bub());
`endif
    cycle("add_mem");
    mem_wb_en = 0;

    // LDR r1 in EX, then ADD r2, r1, #1: load-use stalls in both builds
    ex_wb_en = 1; ex_mem_read = 1; ex_dst = 4'd1;
    ins = dp(4'hE, 1, 4'b0100, 0, 4'd1, 4'd2, 12'h001);
    drive(1, ins, 32'h110);
    chk_comb("load_use", 1, 0);
    sb.push_back(bub()); cycle("load_use");
    ex_wb_en = 0; ex_mem_read = 0;
    chk_comb("load_use_retry", 0, 1);
    sb.push_back(mk(ins, 32'h110, 32'h11, 32'h11, 4'd2, 4'd1, 4'd1, 4'b0010, 1, 0, 0, 0, 0, 1));
    cycle("load_use_retry");

    // ADDEQ r6, r2, r3 with Z=0 (fail) then Z=1 (pass)
    ins = dp(4'h0, 0, 4'b0100, 0, 4'd2, 4'd6, 12'h003);
    drive(1, ins, 32'h114);
    status_register = 4'b0000;
    chk_comb("addeq_z0", 0, 1);
    sb.push_back(mk(ins, 32'h114, 5, 7, 4'd6, 4'd2, 4'd3, 4'b0000, 0, 0, 0, 0, 0, 0));
    cycle("addeq_z0");
    status_register = 4'b0100;
    sb.push_back(mk(ins, 32'h114, 5, 7, 4'd6, 4'd2, 4'd3, 4'b0010, 1, 0, 0, 0, 0, 0));
    cycle("addeq_z1");
    status_register = 4'b0000;

    // MOV with cond 1111 always fails; MOV #imm reads no source so r0 in EX is harmless
    ex_wb_en = 1; ex_dst = 4'd0;
    ins = dp(4'hF, 1, 4'b1101, 0, 4'd0, 4'd7, 12'h009);
    drive(1, ins, 32'h118);
    chk_comb("mov_nv", 0, 1);
    sb.push_back(mk(ins, 32'h118, 0, 0, 4'd7, 4'd0, 4'd9, 4'b0000, 0, 0, 0, 0, 0, 1));
    cycle("mov_nv");
    ex_wb_en = 0;

    // STR r3, [r2]: src2 comes from Rd
    ins = mem(0, 4'd2, 4'd3, 12'h004);
    drive(1, ins, 32'h11C);
    sb.push_back(mk(ins, 32'h11C, 5, 7, 4'd3, 4'd2, 4'd3, 4'b0010, 0, 0, 1, 0, 0, 1));
    cycle("str");

    // LDR r4, [r2]
    ins = mem(1, 4'd2, 4'd4, 12'h004);
    drive(1, ins, 32'h120);
    sb.push_back(mk(ins, 32'h120, 5, 0, 4'd4, 4'd2, 4'd4, 4'b0010, 1, 1, 0, 0, 0, 1));
    cycle("ldr");

    // B
    ins = {4'hE, 4'b1010, 24'h000010};
    drive(1, ins, 32'h124);
    sb.push_back(mk(ins, 32'h124, 0, 0, 4'd0, 4'd0, 4'd0, 4'b0000, 0, 0, 0, 1, 0, 0));
    cycle("branch");

    // MOVS r7, #9 then stall for 3 cycles with a flush in the 2nd
    ins = dp(4'hE, 1, 4'b1101, 1, 4'd0, 4'd7, 12'h009);
    drive(1, ins, 32'h128);
    held = mk(ins, 32'h128, 0, 0, 4'd7, 4'd0, 4'd9, 4'b0001, 1, 0, 0, 0, 1, 1);
    sb.push_back(held); cycle("movs");
    ins = dp(4'hE, 0, 4'b0001, 0, 4'd2, 4'd8, 12'h003);
    drive(1, ins, 32'h12C);
    idex.ex_stall = 1;
    chk_comb("stall1", 0, 0);
    sb.push_back(held); cycle("stall1_hold");
    idex.flush = 1;
    chk_comb("stall2_flush", 0, 0);
    sb.push_back(bub()); cycle("stall2_flush");
    idex.flush = 0;
    sb.push_back(bub()); cycle("stall3_hold");
    idex.ex_stall = 0;
    chk_comb("eor", 0, 1);
    sb.push_back(mk(ins, 32'h12C, 5, 7, 4'd8, 4'd2, 4'd3, 4'b1000, 1, 0, 0, 0, 0, 0));
    cycle("eor");

    // Write-through of r3, then an ignored write to r15
    wb_en = 1; wb_addr = 4'd3; wb_data = 32'hDEAD;
    ins = dp(4'hE, 0, 4'b0100, 0, 4'd2, 4'd9, 12'h003);
    drive(1, ins, 32'h130);
    sb.push_back(mk(ins, 32'h130, 5, 32'hDEAD, 4'd9, 4'd2, 4'd3, 4'b0010, 1, 0, 0, 0, 0, 0));
    cycle("wt_r3");
    wb_addr = 4'd15; wb_data = 32'h1234;
    ins = dp(4'hE, 0, 4'b0100, 0, 4'd15, 4'd10, 12'h00F);
    drive(1, ins, 32'h134);
    sb.push_back(mk(ins, 32'h134, 0, 0, 4'd10, 4'd15, 4'd15, 4'b0010, 1, 0, 0, 0, 0, 0));
    cycle("wt_r15");
    wb_en = 0;
    ins = dp(4'hE, 0, 4'b0100, 0, 4'd3, 4'd11, 12'h00F);
    drive(1, ins, 32'h138);
    sb.push_back(mk(ins, 32'h138, 32'hDEAD, 0, 4'd11, 4'd3, 4'd15, 4'b0010, 1, 0, 0, 0, 0, 0));
    cycle("rd_r3_r15");

    // Reset during a stall clears the ID/EX register and the register file
    ins = dp(4'hE, 0, 4'b0100, 0, 4'd2, 4'd1, 12'h003);
    drive(1, ins, 32'h13C);
    held = mk(ins, 32'h13C, 5, 32'hDEAD, 4'd1, 4'd2, 4'd3, 4'b0010, 1, 0, 0, 0, 0, 0);
    sb.push_back(held); cycle("pre_rst");
    idex.ex_stall = 1;
    sb.push_back(held); cycle("pre_rst_hold");
    rst = 1'b0;
    sb.push_back(zero()); cycle("rst_mid_stall");
    rst = 1'b1; idex.ex_stall = 0;
    drive(0, ins, 32'h13C);
    sb.push_back(bub()); cycle("post_rst_idle");
    drive(1, ins, 32'h140);
    sb.push_back(mk(ins, 32'h140, 0, 0, 4'd1, 4'd2, 4'd3, 4'b0010, 1, 0, 0, 0, 0, 0));
    cycle("post_rst_rf");
    drive(0, 32'h0, 32'h0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
